// File: rtl/wb_stage.sv
// Writeback stage: aligns/extends load data and drives the regfile write port, counts retired instructions.
// Latency: non-load writes one cycle after accept; loads write one cycle after the mem_rvalid edge.
// Backpressure: in_ready drops while a load waits for data and while rst is held low.
module wb_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_wreg,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  input  logic [1:0]            in_addr_lo,
  input  logic [XLEN-1:0]       in_result,
  input  logic                  mem_rvalid,
  input  logic [XLEN-1:0]       mem_rdata,
  output logic [REG_ADDR_W-1:0] waddr,
  output logic                  we,
  output logic [XLEN-1:0]       wdata,
  output logic [63:0]           instret,
  output logic                  bad_load
);

  typedef enum logic {S_IDLE = 1'b0, S_LOAD_WAIT = 1'b1} state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  state_e state_q, state_d;

  logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
  logic                  we_q, we_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic [63:0]           instret_q, instret_d;
  logic                  bad_q, bad_d;

  // Load context captured at accept time, consumed when data returns.
  logic [REG_ADDR_W-1:0] ld_rd_q, ld_rd_d;
  logic                  ld_wreg_q, ld_wreg_d;
  logic [2:0]            ld_f3_q, ld_f3_d;
  logic [1:0]            ld_lo_q, ld_lo_d;

  logic            accept;
  logic            data_done;
  logic            ld_bad;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_result;

  assign accept    = in_valid && in_ready;
  assign data_done = (state_q == S_LOAD_WAIT) && mem_rvalid;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next state: a load parks the stage until its data pulse arrives.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (accept && in_is_load) state_d = S_LOAD_WAIT;
      S_LOAD_WAIT: if (mem_rvalid)           state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // FSM output: ready only in IDLE and never while reset is asserted.
  always_comb begin
    in_ready = 1'b0;
    if (rst && state_q == S_IDLE) in_ready = 1'b1;
  end

  // Misalignment / illegal width check on the captured load.
  always_comb begin
    ld_bad = 1'b0;
    unique case (ld_f3_q)
      F3_LB, F3_LBU: ld_bad = 1'b0;
      F3_LH, F3_LHU: ld_bad = ld_lo_q[0];
      F3_LW:         ld_bad = (ld_lo_q != 2'b00);
      default:       ld_bad = 1'b1;
    endcase
  end

  // Lane select from the aligned word, then width-specific extension.
  always_comb begin
    ld_byte   = 8'(mem_rdata >> {ld_lo_q, 3'b000});
    ld_half   = 16'(mem_rdata >> {ld_lo_q[1], 4'b0000});
    ld_result = mem_rdata;
    unique case (ld_f3_q)
      F3_LB:   ld_result = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      F3_LBU:  ld_result = {{(XLEN-8){1'b0}}, ld_byte};
      F3_LH:   ld_result = {{(XLEN-16){ld_half[15]}}, ld_half};
      F3_LHU:  ld_result = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_result = mem_rdata;
    endcase
  end

  // Writeback, retire counter, sticky error and load context next-state.
  always_comb begin
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    instret_d = instret_q;
    bad_d     = bad_q;
    ld_rd_d   = ld_rd_q;
    ld_wreg_d = ld_wreg_q;
    ld_f3_d   = ld_f3_q;
    ld_lo_d   = ld_lo_q;
    if (accept) begin
      if (in_is_load) begin
        ld_rd_d   = in_rd;
        ld_wreg_d = in_wreg;
        ld_f3_d   = in_funct3;
        ld_lo_d   = in_addr_lo;
      end else begin
        waddr_d   = in_rd;
        wdata_d   = in_result;
        we_d      = in_wreg && (in_rd != '0);
        instret_d = instret_q + 64'd1;
      end
    end else if (data_done) begin
      // A bad load still retires but leaves the write data untouched.
      waddr_d   = ld_rd_q;
      instret_d = instret_q + 64'd1;
      if (ld_bad) begin
        bad_d = 1'b1;
      end else begin
        wdata_d = ld_result;
        we_d    = ld_wreg_q && (ld_rd_q != '0);
      end
    end
  end

  // Datapath registers; reset abandons any pending load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      waddr_q   <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      instret_q <= '0;
      bad_q     <= 1'b0;
      ld_rd_q   <= '0;
      ld_wreg_q <= 1'b0;
      ld_f3_q   <= '0;
      ld_lo_q   <= '0;
    end else begin
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      instret_q <= instret_d;
      bad_q     <= bad_d;
      ld_rd_q   <= ld_rd_d;
      ld_wreg_q <= ld_wreg_d;
      ld_f3_q   <= ld_f3_d;
      ld_lo_q   <= ld_lo_d;
    end
  end

  assign waddr    = waddr_q;
  assign we       = we_q;
  assign wdata    = wdata_q;
  assign instret  = instret_q;
  assign bad_load = bad_q;

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the RISC-V core. Accepts retiring instructions from the memory stage over a valid/ready handshake, waits for load data from data memory, aligns and sign/zero-extends it, and drives the register file write port (`waddr`/`we`/`wdata`). It also keeps the 64-bit retired-instruction counter.

## Interface

Parameters:
- `XLEN`, 32: data width.
- `REG_ADDR_W`, 5: register address width.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-low (`rst`==0 at a rising edge resets).
- `in_valid` in 1: memory stage presents an instruction.
- `in_ready` out 1: stage can accept an instruction.
- `in_rd` in REG_ADDR_W: destination register.
- `in_wreg` in 1: instruction writes `rd`.
- `in_is_load` in 1: instruction is a load.
- `in_funct3` in 3: load width. 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `in_addr_lo` in 2: low bits of the load address.
- `in_result` in XLEN: non-load result.
- `mem_rvalid` in 1: load data valid, one-cycle pulse.
- `mem_rdata` in XLEN: naturally aligned memory word.
- `waddr` out REG_ADDR_W: register file write address.
- `we` out 1: register file write enable.
- `wdata` out XLEN: register file write data.
- `instret` out 64: retired-instruction count.
- `bad_load` out 1: sticky flag for a misaligned load or illegal `funct3`.

## Operation

- FSM states:
  - **IDLE**: `in_ready`=1 (0 while `rst`=0).
  - **LOAD_WAIT**: `in_ready`=0.
- **Accept**: a transfer happens on an edge where `in_valid`=1 and `in_ready`=1.
- **Non-load accepted**:
  - Register `waddr`=`in_rd`, `wdata`=`in_result`, `we`=`in_wreg` && `in_rd`!=0.
  - Increment `instret`.
  - Stay in IDLE, so back-to-back transfers are allowed every cycle.
- **Load accepted**:
  - Capture `rd`, `wreg`, `funct3` and `addr_lo`; go to LOAD_WAIT.
  - `we` drops to 0 at that edge.
- **LOAD_WAIT**:
  - Without `mem_rvalid`, hold and keep `we`=0.
  - On `mem_rvalid`, form the result, register `waddr`/`wdata`/`we`, increment `instret`, and return to IDLE.
- **Load result formation**:
  - Byte B = `mem_rdata`[8·addr_lo +: 8].
  - Half H = `mem_rdata`[16·addr_lo[1] +: 16].
  - LB = sext(B); LBU = zext(B); LH = sext(H); LHU = zext(H); LW = `mem_rdata`.
- **Bad loads**:
  - A load is bad if it is LH/LHU with addr_lo[0]=1, LW with addr_lo!=0, or has `funct3` ∈ {011, 110, 111}.
  - Still wait for `mem_rvalid`.
  - Then force `we`=0, keep `wdata` unchanged, set `bad_load`=1 until reset, and still increment `instret`.
- **Writes to x0**: never produce `we`=1, but still count as retired.
- **`mem_rvalid` outside LOAD_WAIT**: ignored.
- **Arithmetic**:
  - `instret` wraps modulo 2^64.
  - Extension is to XLEN bits.

## Timing

- **Reset values**: at a rising edge with `rst`=0:
  - State IDLE; `we`=0, `waddr`=0, `wdata`=0, `instret`=0, `bad_load`=0.
  - `in_ready`=0 combinationally while `rst`=0.
- **Non-load latency**: accepted at edge N → `we`/`waddr`/`wdata` valid in cycle N+1, `instret` updated in cycle N+1.
- **`we` pulse width**: `we` is high for exactly one cycle per write unless the next accepted instruction also writes.
- **Load latency**:
  - Accepted at edge N, `mem_rvalid` sampled at edge M (M ≥ N+1).
  - Write visible in cycle M+1; `in_ready`=1 in cycle M+1.
  - Minimum load occupancy is 2 cycles.
- **Forwarding**: the register file forwards same-cycle `wdata` to its read ports, so no bypass is needed here.
- **Reset mid-load**: abandon the pending load with no write and no `instret` increment. A `mem_rvalid` in any later cycle is ignored in IDLE.

## Test plan

1. **Reset**: hold `rst`=0 for 2 cycles → `we`=0, `waddr`=0, `wdata`=0, `instret`=0, `bad_load`=0, `in_ready`=0. Release → `in_ready`=1 in the next cycle.
2. **Back-to-back ALU**: non-loads with rd=1/0x11, rd=2/0x22, rd=0/0x33 on consecutive edges → `we`=1 with (1, 0x11) then (2, 0x22), then `we`=0. `instret`=3. `in_ready` never drops.
3. **LB, sign-extended**: LB, addr_lo=3, `mem_rvalid` 4 cycles later with `mem_rdata`=0x80FF_0102 → `in_ready`=0 for 5 cycles, `wdata`=0xFFFF_FF80, `we`=1 for one cycle.
4. **Halfword and word loads** on `mem_rdata`=0x8001_1234:
   - LHU addr_lo=2 → 0x0000_8001.
   - LH addr_lo=2 → 0xFFFF_8001.
   - LW addr_lo=0 → 0x8001_1234.
   - LBU addr_lo=1 → 0x0000_0012.
5. **Bad loads**: LW addr_lo=1, then `funct3`=011 → no `we`, `bad_load`=1 and it stays 1. `instret` increments by 2.
6. **Reset during LOAD_WAIT**: `rst`=0 for one cycle, then `mem_rvalid`=1 → no write, `instret` unchanged from 0, state IDLE, `in_ready`=1.
